// File: rtl/avalon_st_frame_source.sv
// rtl/avalon_st_frame_source.sv - Avalon-ST grayscale frame source with internal frame buffer.
// Optional generated (x+y) test pattern under macro TEST_PATTERN_EN.
module avalon_st_frame_source #(
    parameter int IMG_X_SIZE = 320,
    parameter int IMG_Y_SIZE = 240,
    parameter int ADDR_W     = 17
) (
    input  logic              csi_clkrst_clk,
    input  logic              csi_clkrst_reset,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_data_i,
    input  logic              start_i,
    input  logic              test_pattern_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic              aso_source1_ready,
    output logic [7:0]        aso_source1_data,
    output logic              aso_source1_startofpacket,
    output logic              aso_source1_endofpacket,
    output logic              aso_source1_valid
);
    localparam int N = IMG_X_SIZE * IMG_Y_SIZE;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data_q;
    logic [7:0]        pixel;
    logic [7:0]        mem [N];
    logic              busy;
    logic              xfer;

    assign busy = (state_q == S_PRIME) || (state_q == S_STREAM);
    assign xfer = (state_q == S_STREAM) && aso_source1_ready;

    // rd_addr points at the pixel to present next cycle, so a transfer never stalls on the RAM.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        rd_addr = index_q;
        case (state_q)
            S_IDLE: begin
                index_d = '0;
                if (start_i) state_d = S_PRIME;
            end
            S_PRIME: begin
                rd_addr = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (xfer) begin
                    if (index_q == LAST_IDX) begin
                        state_d = S_DONE;
                        index_d = '0;
                        rd_addr = '0;
                    end else begin
                        index_d = index_q + 1'b1;
                        rd_addr = index_q + 1'b1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge csi_clkrst_clk or posedge csi_clkrst_reset) begin
        if (csi_clkrst_reset) begin
            state_q   <= S_IDLE;
            index_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            rd_data_q <= mem[rd_addr];
        end
    end

    // The buffer survives reset; writes are locked out while a frame is in flight.
    always_ff @(posedge csi_clkrst_clk) begin
        if (wr_en_i && !busy && ({1'b0, wr_addr_i} < (ADDR_W + 1)'(N)))
            mem[wr_addr_i] <= wr_data_i;
    end

`ifdef TEST_PATTERN_EN
    logic              tp_q;
    logic [ADDR_W-1:0] x_q, y_q;

    always_ff @(posedge csi_clkrst_clk or posedge csi_clkrst_reset) begin
        if (csi_clkrst_reset) begin
            tp_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
        end else if (state_q == S_IDLE) begin
            x_q <= '0;
            y_q <= '0;
            if (start_i) tp_q <= test_pattern_i;
        end else if (xfer) begin
            if (x_q == ADDR_W'(IMG_X_SIZE - 1)) begin
                x_q <= '0;
                y_q <= y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    assign pixel = tp_q ? 8'({1'b0, x_q} + {1'b0, y_q}) : rd_data_q;
`else
    logic unused_test_pattern;
    assign unused_test_pattern = test_pattern_i;
    assign pixel = rd_data_q;
`endif

    assign busy_o                    = busy;
    assign done_o                    = (state_q == S_DONE);
    assign aso_source1_valid         = (state_q == S_STREAM);
    assign aso_source1_data          = aso_source1_valid ? pixel : 8'h00;
    assign aso_source1_startofpacket = aso_source1_valid && (index_q == '0);
    assign aso_source1_endofpacket   = aso_source1_valid && (index_q == LAST_IDX);
endmodule

// File: tb/tb_avalon_st_frame_source.sv
// tb/tb_avalon_st_frame_source.sv - scoreboard bench for avalon_st_frame_source (4x3 frame).
module tb_avalon_st_frame_source;
    localparam int X  = 4;
    localparam int Y  = 3;
    localparam int N  = X * Y;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          start = 1'b0;
    logic          test_pattern = 1'b0;
    logic          busy, done;
    logic          ready = 1'b0;
    logic [7:0]    data;
    logic          sop, eop, valid;

    avalon_st_frame_source #(.IMG_X_SIZE(X), .IMG_Y_SIZE(Y), .ADDR_W(AW)) dut (
        .csi_clkrst_clk            (clk),
        .csi_clkrst_reset          (rst),
        .wr_en_i                   (wr_en),
        .wr_addr_i                 (wr_addr),
        .wr_data_i                 (wr_data),
        .start_i                   (start),
        .test_pattern_i            (test_pattern),
        .busy_o                    (busy),
        .done_o                    (done),
        .aso_source1_ready         (ready),
        .aso_source1_data          (data),
        .aso_source1_startofpacket (sop),
        .aso_source1_endofpacket   (eop),
        .aso_source1_valid         (valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [7:0] d; logic s; logic e;} beat_t;

    int         checks = 0;
    int         failures = 0;
    beat_t      sb[$];
    logic [7:0] model [N];
    int         beats_seen = 0;
    int         ready_mode = 0;
    logic       stall_prev = 1'b0;
    logic       eop_prev = 1'b0;
    beat_t      held;
    beat_t      exp_beat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // 0: ready high, 1: toggling, 2: random, 3: held low
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = ~ready;
            2:       ready = 1'($urandom_range(0, 1));
            default: ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            eop_prev   = 1'b0;
        end else begin
            chk("done_pulse", {31'b0, done}, {31'b0, eop_prev});
            if (stall_prev) begin
                chk("hold_valid", {31'b0, valid}, 32'd1);
                chk("hold_beat", {22'b0, data, sop, eop}, {22'b0, held});
            end
            if (valid && ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h required=none", data);
                end else begin
                    exp_beat = sb.pop_front();
                    chk("beat", {22'b0, data, sop, eop}, {22'b0, exp_beat});
                end
                beats_seen++;
            end
            stall_prev = valid && !ready;
            held       = {data, sop, eop};
            eop_prev   = valid && ready && eop;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input bit tp);
        for (int i = 0; i < N; i++) begin
            beat_t b;
            b.d = tp ? 8'((i % X) + (i / X)) : model[i];
            b.s = (i == 0);
            b.e = (i == N - 1);
            sb.push_back(b);
        end
    endtask

    task automatic write_px(input int a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        model[a] = d;
    endtask

    task automatic start_frame(input bit tp);
        start = 1'b1; test_pattern = tp;
        tick();
        start = 1'b0; test_pattern = 1'b0;
    endtask

    task automatic wait_done(input string name, output int cycles);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done) break;
        end
        cycles = k;
        chk({name, "_done_seen"}, {31'b0, k < 400}, 32'd1);
        chk({name, "_drained"}, sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int cyc, base, k;
        tick(3);
        chk("rst_outputs", {26'b0, valid, sop, eop, busy, done, |data}, 32'd0);
        rst = 1'b0;
        tick();

        // Contiguous frame 0..11: done visible 13 negedges after the start edge.
        for (int i = 0; i < N; i++) write_px(i, 8'(i));
        ready_mode = 0;
        tick(2);
        push_frame(0);
        start_frame(0);
        wait_done("frame_contig", cyc);
        chk("frame_latency", cyc, 32'd13);
        tick(2);

        ready_mode = 1;
        push_frame(0);
        start_frame(0);
        wait_done("frame_toggle", cyc);
        tick(2);

        // Random data, random ready; start and write during busy are ignored.
        for (int i = 0; i < N; i++) write_px(i, 8'($urandom));
        ready_mode = 2;
        push_frame(0);
        start_frame(0);
        tick(3);
        start = 1'b1; wr_en = 1'b1; wr_addr = AW'(5); wr_data = 8'hAA;
        tick();
        start = 1'b0; wr_en = 1'b0;
        wait_done("frame_busy_ignore", cyc);
        tick(20);
        chk("single_packet_busy", {31'b0, busy}, 32'd0);

        // Reset right after beat 6 is accepted.
        ready_mode = 0;
        tick(2);
        push_frame(0);
        base = beats_seen;
        start_frame(0);
        for (k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (beats_seen >= base + 7) break;
        end
        chk("reached_beat6", {31'b0, k < 100}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_valid_eop", {29'b0, valid, eop, busy}, 32'd0);
        sb.delete();
        tick(2);
        rst = 1'b0;
        tick();
        push_frame(0);
        start_frame(0);
        wait_done("frame_after_rst", cyc);
        chk("after_rst_latency", cyc, 32'd13);
        tick(2);

        // Stalled start: valid with pixel 0 and sop at edge k+2, held until ready.
        ready_mode = 3;
        tick(2);
        push_frame(0);
        start_frame(0);
        @(negedge clk);
        chk("prime_no_valid", {30'b0, valid, busy}, 32'd1);
        @(negedge clk);
        chk("first_beat_vs", {30'b0, valid, sop}, 32'd3);
        chk("first_beat_data", {24'b0, data}, {24'b0, model[0]});
        repeat (4) @(negedge clk);
        ready_mode = 0;
        wait_done("frame_stall", cyc);
        tick(2);

        // Write and start in the same idle cycle.
        ready_mode = 2;
        wr_en = 1'b1; wr_addr = '0; wr_data = 8'($urandom); model[0] = wr_data;
        push_frame(0);
        start_frame(0);
        wr_en = 1'b0;
        wait_done("frame_wr_start", cyc);
        tick(2);

`ifdef TEST_PATTERN_EN
        ready_mode = 2;
        push_frame(1);
        start_frame(1);
        wait_done("frame_pattern", cyc);
        tick(2);
        push_frame(0);
        start_frame(0);
        wait_done("frame_after_pattern", cyc);
        tick(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
